config_frame_loader: RTL and testbench

- Configuration front-end that feeds the fabric's switch boxes and other tiles.
- Accepts a byte stream over a valid/ready handshake and assembles framed 32-bit configuration words.
- Checks each frame, then drives the shared config_data bus plus a one-hot config_en pulse to the addressed tile.
- Sits directly upstream of every tile's config_data/config_en inputs.

---
 rtl/cfg_pkg.sv | 29 ++
 rtl/config_en_decoder.sv | 15 +
 rtl/config_frame_loader.sv | 134 +++++++++++++
 tb/tb_config_frame_loader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared constants, state encoding and error codes for the configuration frame loader.
package cfg_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         FRAME_LEN = 7;
   localparam int         CONFIG_W  = 32;

   typedef enum logic [2:0] {
      S_HUNT   = 3'd0,
      S_ADDR   = 3'd1,
      S_D0     = 3'd2,
      S_D1     = 3'd3,
      S_D2     = 3'd4,
      S_D3     = 3'd5,
      S_CHK    = 3'd6,
      S_COMMIT = 3'd7
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_CHECKSUM = 2'd1;
   localparam logic [1:0] ERR_ADDRESS  = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   // Saturating increment for the 8-bit reject counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/config_en_decoder.sv
// Address to one-hot tile write strobe, asserted only while commit is high.
module config_en_decoder #(
   parameter int NUM_TARGETS = 16,
   parameter int ADDR_W      = 8
) (
   input  logic [ADDR_W-1:0]      addr,
   input  logic                   commit,
   output logic [NUM_TARGETS-1:0] en
);

   for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_dec
      assign en[gi] = commit && (addr == ADDR_W'(gi));
   end

endmodule

// File: rtl/config_frame_loader.sv
// Assembles SYNC/ADDR/D0-D3/CHK byte frames into 32-bit config words and
// strobes the addressed tile for one cycle after a frame passes its checks.
module config_frame_loader
   import cfg_pkg::*;
#(
   parameter int NUM_TARGETS = 16,
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT     = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [CONFIG_W-1:0]    config_data,
   output logic [NUM_TARGETS-1:0] config_en,
   output logic [15:0]            frame_count,
   output logic [7:0]             err_count,
   output logic [1:0]             last_err,
   output logic                   busy
);

   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W:0] NT = (ADDR_W + 1)'(NUM_TARGETS);

   state_t                state_reg, state_next;
   logic [ADDR_W-1:0]     addr_reg, addr_next;
   logic [CONFIG_W-1:0]   word_reg, word_next;
   logic [IDLE_W-1:0]     idle_reg, idle_next;
   logic [CONFIG_W-1:0]   config_data_reg, config_data_next;
   logic [15:0]           frame_count_reg, frame_count_next;
   logic [7:0]            err_count_reg, err_count_next;
   logic [1:0]            last_err_reg, last_err_next;

   logic                  xfer;
   logic                  in_frame;
   logic [7:0]            chk_calc;

   assign in_ready = (state_reg != S_COMMIT);
   assign xfer     = in_valid && in_ready;
   assign in_frame = (state_reg != S_HUNT) && (state_reg != S_COMMIT);
   assign chk_calc = addr_reg ^ word_reg[7:0] ^ word_reg[15:8]
                   ^ word_reg[23:16] ^ word_reg[31:24];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= S_HUNT;
         addr_reg        <= '0;
         word_reg        <= '0;
         idle_reg        <= '0;
         config_data_reg <= '0;
         frame_count_reg <= '0;
         err_count_reg   <= '0;
         last_err_reg    <= ERR_NONE;
      end else begin
         state_reg       <= state_next;
         addr_reg        <= addr_next;
         word_reg        <= word_next;
         idle_reg        <= idle_next;
         config_data_reg <= config_data_next;
         frame_count_reg <= frame_count_next;
         err_count_reg   <= err_count_next;
         last_err_reg    <= last_err_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      addr_next        = addr_reg;
      word_next        = word_reg;
      idle_next        = '0;
      config_data_next = config_data_reg;
      frame_count_next = frame_count_reg;
      err_count_next   = err_count_reg;
      last_err_next    = last_err_reg;

      case (state_reg)
         S_HUNT:   if (xfer && in_data == SYNC_BYTE) state_next = S_ADDR;
         S_ADDR:   if (xfer) begin addr_next = in_data; state_next = S_D0; end
         S_D0:     if (xfer) begin word_next[7:0]   = in_data; state_next = S_D1; end
         S_D1:     if (xfer) begin word_next[15:8]  = in_data; state_next = S_D2; end
         S_D2:     if (xfer) begin word_next[23:16] = in_data; state_next = S_D3; end
         S_D3:     if (xfer) begin word_next[31:24] = in_data; state_next = S_CHK; end
         S_CHK: begin
            if (xfer) begin
               // Checksum failure wins over a bad address.
               if (in_data != chk_calc) begin
                  err_count_next = sat_inc8(err_count_reg);
                  last_err_next  = ERR_CHECKSUM;
                  state_next     = S_HUNT;
               end else if ({1'b0, addr_reg} >= NT) begin
                  err_count_next = sat_inc8(err_count_reg);
                  last_err_next  = ERR_ADDRESS;
                  state_next     = S_HUNT;
               end else begin
                  // Loaded here so the word is on the bus during the strobe cycle.
                  config_data_next = word_reg;
                  frame_count_next = frame_count_reg + 16'd1;
                  last_err_next    = ERR_NONE;
                  state_next       = S_COMMIT;
               end
            end
         end
         S_COMMIT: state_next = S_HUNT;
         default:  state_next = S_HUNT;
      endcase

      if (in_frame && !xfer) begin
         if (idle_reg == IDLE_W'(TIMEOUT - 1)) begin
            err_count_next = sat_inc8(err_count_reg);
            last_err_next  = ERR_TIMEOUT;
            state_next     = S_HUNT;
         end else begin
            idle_next = idle_reg + 1'b1;
         end
      end
   end

   config_en_decoder #(
      .NUM_TARGETS (NUM_TARGETS),
      .ADDR_W      (ADDR_W)
   ) u_decoder (
      .addr   (addr_reg),
      .commit (state_reg == S_COMMIT),
      .en     (config_en)
   );

   assign config_data = config_data_reg;
   assign frame_count = frame_count_reg;
   assign err_count   = err_count_reg;
   assign last_err    = last_err_reg;
   assign busy        = (state_reg != S_HUNT);

endmodule

// File: tb/tb_config_frame_loader.sv
// Scoreboard bench: stimulus queues expected commits, a monitor checks every config_en pulse.
module tb_config_frame_loader;

   localparam int NT  = 16;
   localparam int TMO = 1024;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   config_data;
   logic [NT-1:0] config_en;
   logic [15:0]   frame_count;
   logic [7:0]    err_count;
   logic [1:0]    last_err;
   logic          busy;

   typedef struct {
      logic [15:0] en;
      logic [31:0] data;
      logic [15:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   config_frame_loader #(
      .NUM_TARGETS (NT),
      .ADDR_W      (8),
      .TIMEOUT     (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .config_data (config_data),
      .config_en   (config_en),
      .frame_count (frame_count),
      .err_count   (err_count),
      .last_err    (last_err),
      .busy        (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: any strobe must match the oldest queued commit.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (config_en !== '0) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_commit actual_en=%0h expected=none", config_en);
            end else begin
               e = exp_q.pop_front();
               $display("commit en=%04h data=%08h fc=%0d", config_en, config_data, frame_count);
               check("commit_en", 32'(config_en), 32'(e.en));
               check("commit_data", config_data, e.data);
               check("commit_fc", 32'(frame_count), 32'(e.fc));
               check("commit_ready_low", 32'(in_ready), 32'd0);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge following the transfer edge.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("ready_wait_expired", 32'(in_ready), 32'd1);
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] addr, input logic [31:0] d, input logic [7:0] chk);
      send_byte(8'hA5);
      send_byte(addr);
      send_byte(d[7:0]);
      send_byte(d[15:8]);
      send_byte(d[23:16]);
      send_byte(d[31:24]);
      send_byte(chk);
      in_valid = 1'b0;
   endtask

   task automatic expect_commit(input logic [15:0] en, input logic [31:0] d, input logic [15:0] fc);
      exp_t e;
      e.en = en; e.data = d; e.fc = fc;
      exp_q.push_back(e);
   endtask

   task automatic check_status(input string tag, input logic [31:0] d, input logic [15:0] fc,
                               input logic [7:0] ec, input logic [1:0] le);
      repeat (2) @(negedge clk);
      $display("status %s data=%08h fc=%0d ec=%0d le=%0d", tag, config_data, frame_count, err_count, last_err);
      check({tag, "_data"}, config_data, d);
      check({tag, "_fc"}, 32'(frame_count), 32'(fc));
      check({tag, "_ec"}, 32'(err_count), 32'(ec));
      check({tag, "_le"}, 32'(last_err), 32'(le));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int n;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_en", 32'(config_en), 32'd0);
      check_status("reset", 32'h0, 16'd0, 8'd0, 2'd0);

      // Good frame to tile 2.
      expect_commit(16'h0004, 32'h1234_5678, 16'd1);
      send_frame(8'h02, 32'h1234_5678, 8'h0A);
      check_status("good", 32'h1234_5678, 16'd1, 8'd0, 2'd0);

      // Garbage is discarded while hunting.
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h13);
      in_valid = 1'b0;
      @(negedge clk);
      check("garbage_busy", 32'(busy), 32'd0);
      expect_commit(16'h0004, 32'h1234_5678, 16'd2);
      send_frame(8'h02, 32'h1234_5678, 8'h0A);
      check_status("garbage", 32'h1234_5678, 16'd2, 8'd0, 2'd0);

      // Bad checksum.
      send_frame(8'h02, 32'h1234_5678, 8'h0B);
      check_status("badchk", 32'h1234_5678, 16'd2, 8'd1, 2'd1);

      // Checksum fine but address out of range.
      send_frame(8'h10, 32'h0000_0000, 8'h10);
      check_status("badaddr", 32'h1234_5678, 16'd2, 8'd2, 2'd2);

      // Sync byte value inside the payload is plain data.
      expect_commit(16'h0008, 32'hA5A5_A5A5, 16'd3);
      send_frame(8'h03, 32'hA5A5_A5A5, 8'h03);
      check_status("syncdata", 32'hA5A5_A5A5, 16'd3, 8'd2, 2'd0);

      // Stall after D1: still in frame one cycle short of the limit, aborted at it.
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h78);
      send_byte(8'h56);
      in_valid = 1'b0;
      repeat (TMO - 1) @(negedge clk);
      check("timeout_not_yet", 32'(busy), 32'd1);
      @(negedge clk);
      check("timeout_abort", 32'(busy), 32'd0);
      check_status("timeout", 32'hA5A5_A5A5, 16'd3, 8'd3, 2'd3);
      expect_commit(16'h0004, 32'h1234_5678, 16'd4);
      send_frame(8'h02, 32'h1234_5678, 8'h0A);
      check_status("resend", 32'h1234_5678, 16'd4, 8'd3, 2'd0);

      // Reset after D2 drops the partial frame and clears counters.
      send_byte(8'hA5);
      send_byte(8'h05);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      in_valid = 1'b0;
      reset    = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_status("midreset", 32'h0, 16'd0, 8'd0, 2'd0);
      expect_commit(16'h0020, 32'hCAFE_BABE, 16'd1);
      send_frame(8'h05, 32'hCAFE_BABE, 8'h35);
      check_status("after_reset", 32'hCAFE_BABE, 16'd1, 8'd0, 2'd0);

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("pending_commits", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
